// File: rtl/video_pattern_scheduler.sv
// Frame-synchronous pattern-source scheduler for the HDMI encoder: pixel coordinates,
// line/frame markers and a per-frame source rotator. Define SCHED_BLANK_EN to insert a black frame per switch.
module video_pattern_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int DWELL_FRAMES = 120
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        i_rd,
  input  logic        i_newline,
  input  logic        i_newframe,
  input  logic        i_auto,
  input  logic        i_next,
  input  logic [23:0] i_src0,
  input  logic [23:0] i_src1,
  input  logic [23:0] i_src2,
  input  logic [23:0] i_src3,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_vsync,
  output logic        o_eol,
  output logic        o_eof,
  output logic [7:0]  o_red,
  output logic [7:0]  o_grn,
  output logic [7:0]  o_blu,
  output logic [1:0]  o_sel,
  output logic        o_blank
);
  localparam int DW = ($clog2(DWELL_FRAMES) > 8) ? $clog2(DWELL_FRAMES) : 8;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  typedef enum logic [1:0] {SYNC, SHOW, BLANK} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] dwell, dwell_nxt;
  logic          pending, pending_nxt;
  logic [1:0]    sel_nxt;
  logic          take;
  logic [23:0]   pix;

  always_ff @(posedge clk_25mhz) begin
    if (reset || i_newline) o_x <= '0;
    else if (i_rd)          o_x <= o_x + 12'd1;
    if (reset || i_newframe) o_y <= '0;
    else if (i_newline)      o_y <= o_y + 12'd1;
  end

  assign o_vsync = (o_x == 12'd0) && (o_y == 12'd0);
  assign o_eol   = i_rd && (o_x == 12'(H_ACTIVE - 1));
  assign o_eof   = o_eol && (o_y == 12'(V_ACTIVE - 1));

  // Every decision happens at i_newframe, which lands in vertical blanking.
  always_comb begin
    state_nxt   = state;
    sel_nxt     = o_sel;
    dwell_nxt   = dwell;
    pending_nxt = pending | i_next;
    take        = 1'b0;
    case (state)
      SYNC:  if (i_newframe) state_nxt = SHOW;
      SHOW:
        if (i_newframe) begin
          take = (i_auto && dwell == DWELL_LAST) || pending || i_next;
          if (take) begin
            sel_nxt     = o_sel + 2'd1;
            dwell_nxt   = '0;
            pending_nxt = 1'b0;
`ifdef SCHED_BLANK_EN
            state_nxt   = BLANK;
`else
            state_nxt   = SHOW;
`endif
          end else if (i_auto) begin
            dwell_nxt = dwell + 1'b1;
          end
        end
      BLANK: if (i_newframe) state_nxt = SHOW;
      default: state_nxt = SYNC;
    endcase
    if (!i_auto) dwell_nxt = '0;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state   <= SYNC;
      o_sel   <= 2'd0;
      o_blank <= 1'b1;
      dwell   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_sel   <= sel_nxt;
      o_blank <= (state_nxt != SHOW);
      dwell   <= dwell_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    case (o_sel)
      2'd0:    pix = i_src0;
      2'd1:    pix = i_src1;
      2'd2:    pix = i_src2;
      default: pix = i_src3;
    endcase
    {o_red, o_grn, o_blu} = o_blank ? 24'h0 : pix;
  end
endmodule

// File: tb/tb_video_pattern_scheduler.sv
// Randomized scoreboard bench for video_pattern_scheduler on a reduced 16x8 raster.
module tb_video_pattern_scheduler;
  localparam int H  = 16;
  localparam int V  = 8;
  localparam int DW = 3;
`ifdef SCHED_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic        clk_25mhz = 1'b0;
  logic        reset, i_rd, i_newline, i_newframe, i_auto, i_next;
  logic [23:0] src [4];
  logic [11:0] o_x, o_y;
  logic        o_vsync, o_eol, o_eof, o_blank;
  logic [7:0]  o_red, o_grn, o_blu;
  logic [1:0]  o_sel;

  video_pattern_scheduler #(.H_ACTIVE(H), .V_ACTIVE(V), .DWELL_FRAMES(DW)) dut (
    .clk_25mhz(clk_25mhz), .reset(reset), .i_rd(i_rd), .i_newline(i_newline),
    .i_newframe(i_newframe), .i_auto(i_auto), .i_next(i_next),
    .i_src0(src[0]), .i_src1(src[1]), .i_src2(src[2]), .i_src3(src[3]),
    .o_x(o_x), .o_y(o_y), .o_vsync(o_vsync), .o_eol(o_eol), .o_eof(o_eof),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_sel(o_sel), .o_blank(o_blank));

  always #5 clk_25mhz = ~clk_25mhz;

  typedef struct {
    logic [11:0] x, y;
    logic        vs, eol, eof, blank;
    logic [1:0]  sel;
    logic [23:0] rgb;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Frame-level reference: position counts, shown source, mode (0 sync, 1 show, 2 black frame),
  // frames shown of the current source, and an outstanding manual step.
  int mx, my, msel, mmode, mshown;
  bit mpend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; msel = 0; mmode = 0; mshown = 0; mpend = 1'b0;
  endtask

  task automatic model_update(input bit rd, input bit nl, input bit nf, input bit nx, input bit rst);
    bit take;
    if (rst) begin model_reset(); return; end
    if (nl) mx = 0; else if (rd) mx = (mx + 1) % 4096;
    if (nf) my = 0; else if (nl) my = my + 1;
    take = 1'b0;
    if (nf) begin
      if (mmode != 1) mmode = 1;
      else begin
        take = (i_auto && mshown == DW - 1) || mpend || nx;
        if (take) begin
          msel = (msel + 1) % 4;
          mshown = 0;
          if (BLANK_EN) mmode = 2;
        end else if (i_auto) mshown++;
      end
    end
    mpend = take ? 1'b0 : (mpend | nx);
    if (!i_auto) mshown = 0;
  endtask

  task automatic step(input bit rd, input bit nl, input bit nf, input bit nx, input bit rst);
    exp_t e;
    i_rd = rd; i_newline = nl; i_newframe = nf; i_next = nx; reset = rst;
    e.x     = 12'(mx);
    e.y     = 12'(my);
    e.vs    = (mx == 0) && (my == 0);
    e.eol   = rd && (mx == H - 1);
    e.eof   = e.eol && (my == V - 1);
    e.blank = (mmode != 1);
    e.sel   = 2'(msel);
    e.rgb   = e.blank ? 24'h0 : src[msel];
    q.push_back(e);
    @(posedge clk_25mhz);
    model_update(rd, nl, nf, nx, rst);
    #1;
  endtask

  // One raster: H reads per line with random gaps, newline, then newframe.
  // nx_cnt pulses start at (nx_x, nx_y); a reset at (rst_x, rst_y) abandons the frame.
  task automatic frame(input int nx_x, input int nx_y, input int nx_cnt, input bit nx_nf,
                       input bit combo, input int rst_x, input int rst_y);
    for (int ln = 0; ln < V; ln++) begin
      for (int c = 0; c < H; c++) begin
        bit nx = (nx_x >= 0) && (ln == nx_y) && (c >= nx_x) &&
                 (c < nx_x + 2 * nx_cnt) && (((c - nx_x) % 2) == 0);
        if ($urandom_range(3) == 0) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ln == rst_y && c == rst_x) begin
          step(1'b1, 1'b0, 1'b0, nx, 1'b1);
          return;
        end
        step(1'b1, 1'b0, 1'b0, nx, 1'b0);
      end
      if (!(combo && ln == V - 1)) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, combo, 1'b1, nx_nf, 1'b0);
  endtask

  always @(negedge clk_25mhz) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("x", 32'(o_x), 32'(e.x));
      chk("y", 32'(o_y), 32'(e.y));
      chk("vsync", 32'(o_vsync), 32'(e.vs));
      chk("eol", 32'(o_eol), 32'(e.eol));
      chk("eof", 32'(o_eof), 32'(e.eof));
      chk("blank", 32'(o_blank), 32'(e.blank));
      chk("sel", 32'(o_sel), 32'(e.sel));
      chk("rgb", 32'({o_red, o_grn, o_blu}), 32'(e.rgb));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    src[0] = 24'hFF0000; src[1] = 24'h00FF00; src[2] = 24'h0000FF; src[3] = 24'hFFFFFF;
    reset = 1'b1; i_rd = 1'b0; i_newline = 1'b0; i_newframe = 1'b0; i_auto = 1'b0; i_next = 1'b0;
    repeat (2) @(posedge clk_25mhz);
    #1;
    model_reset();
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Static display, then timed rotation.
    repeat (2) frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);
    i_auto = 1'b1;
    repeat (17) frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);

    // Manual steps: single mid-frame pulse, three pulses collapsing into one.
    i_auto = 1'b0;
    frame(5, 3, 1, 1'b0, 1'b0, -1, -1);
    frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);
    frame(5, 3, 3, 1'b0, 1'b0, -1, -1);
    frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);

    // Step on the newframe itself, then a request inside the following (possibly black) frame.
    frame(-1, 0, 0, 1'b1, 1'b0, -1, -1);
    frame(2, 2, 1, 1'b0, 1'b0, -1, -1);
    repeat (3) frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);

    // Newline and newframe together.
    frame(-1, 0, 0, 1'b0, 1'b1, -1, -1);
    frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);

    // Park on source 2, then reset mid-frame.
    for (int k = 0; k < 8 && msel != 2; k++) frame(-1, 0, 0, 1'b1, 1'b0, -1, -1);
    frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);
    chk("park_sel", 32'(o_sel), 32'd2);
    frame(-1, 0, 0, 1'b0, 1'b0, 8, 4);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) frame(-1, 0, 0, 1'b0, 1'b0, -1, -1);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      i_auto = 1'($urandom_range(1));
      if ($urandom_range(3) == 0)
        for (int k = 0; k < 4; k++) src[k] = 24'($urandom);
      frame(($urandom_range(2) == 0) ? int'($urandom_range(H - 1)) : -1,
            int'($urandom_range(V - 1)), int'($urandom_range(1, 3)),
            1'($urandom_range(4) == 0), 1'($urandom_range(3) == 0), -1, -1);
    end

    repeat (3) @(negedge clk_25mhz);
    chk("drain", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
